// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC register, imem req/gnt/rvalid, fetch buffer to ID
module instr_fetch_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDR  = 32'h8000_0000,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] next_pc_i,
  input  logic             redirect_i,
  output logic [WIDTH-1:0] curr_pc_o,
  output logic             instr_req_o,
  output logic [WIDTH-1:0] instr_addr_o,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  input  logic [WIDTH-1:0] instr_rdata_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  output logic             valid_id_o,
  input  logic             ready_id_i
);
  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] NOP     = WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state;
  state_t           state_nx;
  logic             req_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_nx;
  logic [WIDTH-1:0] out_pc_q;
  logic             discard_q;

  logic [WIDTH-1:0] buf_data [FIFO_DEPTH];
  logic [WIDTH-1:0] buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;

  logic gnt_ok;
  logic rsp;
  logic push;
  logic pop;
  logic empty;

  // A grant only counts once the request is actually visible on the bus
  assign gnt_ok      = (state == REQ) && req_q && instr_gnt_i;
  // Responses outside WAIT are leftovers from before a reset and are ignored
  assign rsp         = (state == WAIT) && instr_rvalid_i;
  assign empty       = (count == '0);
  assign push        = rsp && !discard_q && !redirect_i;
  assign pop         = !empty && ready_id_i && !redirect_i;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  // Next fetch state; a new request is only raised when its response has a free slot
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (redirect_i || (count < DEPTH_C)) state_nx = REQ;
      REQ:     if (gnt_ok) state_nx = WAIT;
      WAIT:    if (rsp) state_nx = (redirect_i || (count_after < DEPTH_C)) ? REQ : IDLE;
      default: state_nx = REQ;
    endcase
  end

  // Fetch PC: redirect wins; a grant of a wrong-path request must not advance past the target
  always_comb begin
    pc_nx = pc_q;
    if (redirect_i)
      pc_nx = next_pc_i;
    else if (gnt_ok && !discard_q)
      pc_nx = next_pc_i;
  end

  // FSM, fetch PC, bus outputs and wrong-path discard flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= REQ;
      req_q     <= 1'b0;
      addr_q    <= BOOT_ADDR;
      pc_q      <= BOOT_ADDR;
      out_pc_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state <= state_nx;
      req_q <= (state_nx == REQ);
      pc_q  <= pc_nx;
      // Address is latched when a request is first raised and then held until granted
      if ((state_nx == REQ) && !((state == REQ) && req_q))
        addr_q <= pc_nx;
      if (gnt_ok)
        out_pc_q <= addr_q;
      if ((state == REQ) && req_q && redirect_i)
        discard_q <= 1'b1;
      else if (state == WAIT) begin
        if (instr_rvalid_i)
          discard_q <= 1'b0;
        else if (redirect_i)
          discard_q <= 1'b1;
      end
    end
  end

  // Fetch buffer pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_after;
    end
  end

  // Fetch buffer storage: instruction word paired with the PC it was fetched from
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data[wptr] <= instr_rdata_i;
      buf_pc[wptr]   <= out_pc_q;
    end
  end

  assign curr_pc_o    = pc_q;
  assign instr_req_o  = req_q;
  assign instr_addr_o = addr_q;
  assign valid_id_o   = !empty;
  assign instr_o      = empty ? NOP : buf_data[rptr];
  assign instr_pc_o   = empty ? '0 : buf_pc[rptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam logic [31:0] BOOT = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] curr_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        valid_id;
  logic        ready_id;

  always #5 clk = ~clk;

  instr_fetch_unit #(.WIDTH(32), .BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .next_pc_i(next_pc), .redirect_i(redirect),
    .curr_pc_o(curr_pc), .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_o(instr),
    .instr_pc_o(instr_pc), .valid_id_o(valid_id), .ready_id_i(ready_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  // stimulus knobs
  int gnt_pct = 100, gnt_wait = 0, rv_min = 1, rv_max = 1, ready_pct = 100;
  int redir_pm = 0, redir_mode = 0, check_adv = 0;
  logic [31:0] redir_fixed = '0;

  // reference model state
  logic        pending = 0;
  logic [31:0] pend_addr = '0;
  int          pend_left = 0;
  int          req_age = 0;
  logic [31:0] exp_pc = BOOT;
  int          cyc = 0, delivered = 0, first_gnt = -1, first_valid = -1, empty_chk = 0;
  logic        prev_req = 0, prev_gnt = 0, prev_redir = 0;
  logic [31:0] prev_addr = '0, prev_target = '0, held_addr = '0;
  logic        log_grants = 0;
  logic [31:0] gq[$];

  task automatic cycle();
    logic [31:0] tgt;
    logic [15:0] lo;
    logic        fired;
    @(negedge clk);
    fired  = 1'b0;
    rvalid = 1'b0;
    rdata  = $urandom;
    if (pending) begin
      pend_left--;
      if (pend_left == 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(pend_addr);
      end
    end
    gnt      = req && (req_age >= gnt_wait) && ($urandom_range(0, 99) < gnt_pct);
    ready_id = ($urandom_range(0, 99) < ready_pct);
    redirect = 1'b0;
    case (redir_mode)
      0: redirect = ($urandom_range(0, 999) < redir_pm);
      1: if (pending && !rvalid) fired = 1'b1;
      2: if (req && req_age == 1 && !gnt) begin fired = 1'b1; held_addr = addr; end
      3: if (rvalid && valid_id) begin fired = 1'b1; ready_id = 1'b1; end
      default: redirect = 1'b0;
    endcase
    if (fired) begin
      redirect   = 1'b1;
      redir_mode = 0;
      gq.delete();
      log_grants = 1'b1;
    end
    lo  = 16'($urandom_range(0, 65535));
    tgt = (redir_fixed != '0) ? redir_fixed : {16'h8000, lo[15:2], 2'b00};
    next_pc = redirect ? tgt : curr_pc + 32'd4;
    #2;
    cyc++;
    if (prev_redir) begin
      chk("flush_valid", valid_id, 1'b0);
      chk("redirect_pc", curr_pc, prev_target);
    end
    if (empty_chk > 0) begin
      chk("flush_empty", valid_id, 1'b0);
      empty_chk--;
    end
    if (prev_req && !prev_gnt) begin
      chk("req_hold", req, 1'b1);
      chk("addr_hold", addr, prev_addr);
    end
    if (check_adv && prev_req && prev_gnt) chk("pc_advance", curr_pc, prev_addr + 32'd4);
    if (req) chk("one_outstanding", pending, 1'b0);
    if (!valid_id) chk("nop_when_empty", instr, NOP);
    if (valid_id && ready_id && !redirect) begin
      chk("id_pc", instr_pc, exp_pc);
      chk("id_instr", instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      delivered++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (redirect) exp_pc = tgt;
    if (fired && redirect && ready_id && rvalid) empty_chk = 2;
    if (rvalid && pending) pending = 1'b0;
    if (req && gnt) begin
      pending   = 1'b1;
      pend_addr = addr;
      pend_left = $urandom_range(rv_min, rv_max);
      if (log_grants) gq.push_back(addr);
      if (first_gnt < 0) first_gnt = cyc;
    end
    req_age     = (req && !gnt) ? req_age + 1 : 0;
    prev_req    = req;
    prev_gnt    = gnt;
    prev_addr   = addr;
    prev_redir  = redirect;
    prev_target = tgt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    #1 rst_n = 1'b0;
    gnt = 0; rvalid = 0; redirect = 0; ready_id = 0; next_pc = BOOT;
    #1;
    chk("rst_curr_pc", curr_pc, BOOT);
    chk("rst_req", req, 1'b0);
    chk("rst_addr", addr, BOOT);
    chk("rst_valid", valid_id, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if (stray) begin
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
    end
    pending = 0; req_age = 0; exp_pc = BOOT; empty_chk = 0;
    prev_req = 0; prev_gnt = 0; prev_redir = 0;
    first_gnt = -1; first_valid = -1;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; next_pc = BOOT; redirect = 0; gnt = 0; rvalid = 0; rdata = '0; ready_id = 0;
    do_reset(1'b0);

    // sequential fetch, immediate grant, one-cycle response
    log_grants = 1; check_adv = 1;
    run(30);
    check_adv = 0;
    chk("n_grants", gq.size() >= 3, 1'b1);
    chk("seq_addr0", gq[0], 32'h8000_0000);
    chk("seq_addr1", gq[1], 32'h8000_0004);
    chk("seq_addr2", gq[2], 32'h8000_0008);
    chk("latency", 32'(first_valid - first_gnt), 32'd2);

    // ID stalls: buffer fills, requests stop; one pop allows exactly one request
    ready_pct = 0;
    run(20);
    chk("stall_req", req, 1'b0);
    chk("stall_valid", valid_id, 1'b1);
    chk("stall_head_pc", instr_pc, exp_pc);
    ready_pct = 100;
    cycle();
    ready_pct = 0;
    gq.delete();
    run(15);
    chk("one_refill", gq.size(), 32'd1);
    chk("refill_idle", req, 1'b0);
    ready_pct = 100;
    run(10);

    // redirect while waiting for a response
    rv_min = 2; rv_max = 2; redir_fixed = 32'h8000_0100; redir_mode = 1;
    run(20);
    chk("wait_redir_addr", gq[0], 32'h8000_0100);

    // redirect in REQ with grant delayed three cycles
    rv_min = 1; rv_max = 1; gnt_wait = 3; redir_fixed = 32'h8000_0200; redir_mode = 2;
    run(25);
    chk("req_redir_held", gq[0], held_addr);
    chk("req_redir_next", gq[1], 32'h8000_0200);
    gnt_wait = 0;
    run(10);

    // redirect coincident with response and ID pop, one entry buffered
    ready_pct = 0; redir_fixed = 32'h8000_0300; redir_mode = 3;
    run(20);
    chk("coinc_fired", redir_mode, 32'd0);
    ready_pct = 100;
    run(10);

    // asynchronous reset while waiting, stray response after release
    rv_min = 3; rv_max = 3;
    for (int i = 0; i < 20 && !pending; i++) cycle();
    chk("reach_wait", pending, 1'b1);
    do_reset(1'b1);
    rv_min = 1; rv_max = 1;
    gq.delete(); log_grants = 1;
    run(10);
    chk("post_rst_addr", gq[0], BOOT);

    // randomized traffic with random redirects
    gnt_pct = 60; rv_min = 1; rv_max = 3; ready_pct = 70; redir_pm = 30; redir_fixed = '0;
    d0 = delivered;
    run(3000);
    chk("progress", (delivered - d0) > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that consumes the next-PC value from the core's PC controller.
- Holds the architectural fetch PC and feeds it back to the controller as the current PC.
- Issues requests on the instruction-memory req/gnt/rvalid interface and buffers the returned instructions with their PCs.
- Presents instructions to the ID stage over a valid/ready handshake and discards wrong-path fetches on redirect.

Parameters:
- WIDTH, 32, address/data width.
- BOOT_ADDR, 32'h8000_0000, fetch PC after reset.
- FIFO_DEPTH, 2, fetch buffer entries (power of 2, >=2).

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- next_pc_i  input  WIDTH  next PC from the PC controller.
- redirect_i  input  1  next_pc_i is non-sequential (jump/branch/trap/mret); flush.
- curr_pc_o  output  WIDTH  fetch PC register, fed back to the PC controller.
- instr_req_o  output  1  memory request.
- instr_addr_o  output  WIDTH  request address.
- instr_gnt_i  input  1  request accepted.
- instr_rvalid_i  input  1  response valid.
- instr_rdata_i  input  WIDTH  response data.
- instr_o  output  WIDTH  instruction to ID.
- instr_pc_o  output  WIDTH  PC of instr_o.
- valid_id_o  output  1  instr_o valid.
- ready_id_i  input  1  ID accepts.

Behaviour:
- Reset values: curr_pc_o=BOOT_ADDR, instr_req_o=0, instr_addr_o=BOOT_ADDR, valid_id_o=0, instr_o=32'h0000_0013 (NOP), instr_pc_o=0. Buffer empty, discard flag 0, state REQ.
- One outstanding transaction max. FSM states: IDLE, REQ, WAIT.
- IDLE:
  - instr_req_o=0.
  - Go to REQ when count<FIFO_DEPTH, or when redirect_i=1.
- REQ:
  - instr_req_o=1, instr_addr_o=curr_pc_o.
  - Request and address held stable until gnt, even across redirect.
  - On gnt: outstanding PC <= curr_pc_o, curr_pc_o <= next_pc_i, go to WAIT.
- WAIT:
  - instr_req_o=0.
  - On rvalid: push {rdata, outstanding PC} unless the discard flag is set, then clear the flag.
  - Next state is REQ if space remains after this cycle's push/pop (count+push-pop<FIFO_DEPTH) or redirect_i=1; otherwise IDLE.
- Space check: a request is issued only if the response is guaranteed a slot. Entering REQ requires count<FIFO_DEPTH.
- redirect_i=1:
  - Buffer flushed that cycle; flush wins over a simultaneous push/pop. valid_id_o=0 next cycle.
  - curr_pc_o <= next_pc_i.
  - If in REQ: discard flag is set for the current request, whether granted this cycle or later.
  - If in WAIT without rvalid this cycle: discard flag set.
  - If in WAIT with rvalid this cycle: response dropped.
- PC update priority: redirect_i > gnt. Without either, curr_pc_o holds.
- Stray rvalid in IDLE/REQ (e.g. after reset mid-transaction) is ignored.
- Buffer output:
  - valid_id_o = !empty; instr_o/instr_pc_o = head entry.
  - instr_o = NOP when empty.
  - Pop when valid_id_o && ready_id_i.
  - Push and pop in the same cycle keep count unchanged.
- Latency: gnt at cycle N, rvalid at N+1, valid_id_o at N+2 (registered buffer).
- Arithmetic: pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Async reset mid-operation returns all state to reset values immediately.

Test Plan:
- Reset release, gnt same cycle as req, rvalid next cycle, next_pc_i=curr_pc_o+4, ready_id_i=1 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; ID sees matching instr_pc_o; curr_pc_o advances on each gnt.
- ready_id_i=0 -> after 2 entries buffered, instr_req_o stays 0 (IDLE). ready_id_i=1 for one cycle -> one pop, exactly one new request.
- redirect_i in WAIT, next_pc_i=0x8000_0100 -> buffer empty, in-flight rdata never reaches ID, next instr_addr_o=0x8000_0100.
- redirect_i in REQ with gnt delayed 3 cycles -> instr_addr_o holds the old address until gnt; that response is discarded; the following request targets the redirect address.
- redirect_i coincident with rvalid and ID pop, buffer holding 1 entry -> valid_id_o=0 next cycle, count=0.
- rst_n_i low during WAIT, rvalid arrives after release -> outputs at reset values, stray rvalid ignored, first request to BOOT_ADDR.
